// File: rtl/dff_arb_pkg.sv
// Shared definitions for the shared-register write arbiter.
package dff_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StWrite = ST_WRITE,
    StAck   = ST_ACK
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return int'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: rotate req so the slot after last_owner sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_select
  import dff_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] last_owner,
  output logic            valid,
  output logic [IdxW-1:0] winner
);

  logic [IdxW-1:0] start;
  logic [NREQ-1:0] rot;
  logic [IdxW-1:0] pe;

  // Both operands are below NREQ, so one conditional subtract is a full modulo.
  function automatic logic [IdxW-1:0] add_mod(input logic [IdxW-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NREQ) begin
      s = s - NREQ;
    end
    return IdxW'(s);
  endfunction

  // Rotate, priority-encode, unrotate.
  always_comb begin
    start = (32'(last_owner) >= NREQ - 1) ? '0 : last_owner + 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rot[i] = req[add_mod(start, i)];
    end
    valid = |rot;
    pe    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pe = IdxW'(i);
      end
    end
    winner = add_mod(start, 32'(pe));
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter that sequences single-cycle writes into one shared
// enabled D register and acknowledges each winner once its write is done.
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  output logic [NREQ-1:0]           gnt,
  output logic                      reg_en,
  output logic [WIDTH-1:0]          reg_d,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   last_owner
);

  localparam int unsigned IdxW = clog2_min1(NREQ);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              reg_en_q, reg_en_d;
  logic [WIDTH-1:0]  reg_d_q, reg_d_d;
  logic              busy_q, busy_d;
  logic [IdxW-1:0]   last_q, last_d;

  logic              sel_valid;
  logic [IdxW-1:0]   sel_winner;
  logic [WIDTH-1:0]  sel_data;

  rr_select #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_select (
    .req        (req),
    .last_owner (last_q),
    .valid      (sel_valid),
    .winner     (sel_winner)
  );

  // Winner's data slice; constant-index mux so unselected slices never leak through.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_winner == IdxW'(i)) begin
        sel_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    data_d   = data_q;
    gnt_d    = '0;
    reg_en_d = 1'b0;
    reg_d_d  = reg_d_q;
    last_d   = last_q;
    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          win_d   = sel_winner;
          data_d  = sel_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        reg_en_d = 1'b1;
        reg_d_d  = data_q;
        state_d  = StAck;
      end
      StAck: begin
        gnt_d[win_q] = 1'b1;
        last_d       = win_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // busy is visible in the same cycles as the write strobe and the acknowledge.
    busy_d = reg_en_d | (|gnt_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      win_q    <= '0;
      data_q   <= '0;
      gnt_q    <= '0;
      reg_en_q <= 1'b0;
      reg_d_q  <= '0;
      busy_q   <= 1'b0;
      last_q   <= IdxW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      data_q   <= data_d;
      gnt_q    <= gnt_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

  assign gnt        = gnt_q;
  assign reg_en     = reg_en_q;
  assign reg_d      = reg_d_q;
  assign busy       = busy_q;
  assign last_owner = last_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Bench for dff_write_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_dff_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  reg_en;
  logic [WIDTH-1:0]      reg_d;
  logic                  busy;
  logic [1:0]            last_owner;
  logic [WIDTH-1:0]      sh_q;

  int checks   = 0;
  int failures = 0;

  // Transaction model: a write sampled at edge s shows reg_en after s+1, gnt after s+2.
  int               m_edge;
  bit               m_pend;
  int               m_start;
  int               m_win;
  logic [WIDTH-1:0] m_data;
  logic [NREQ-1:0]  e_gnt;
  logic             e_reg_en;
  logic [WIDTH-1:0] e_reg_d;
  logic [1:0]       e_last;
  logic [WIDTH-1:0] e_sh;

  dff_write_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wdata      (wdata),
    .gnt        (gnt),
    .reg_en     (reg_en),
    .reg_d      (reg_d),
    .busy       (busy),
    .last_owner (last_owner)
  );

  always #5 clk = ~clk;

  // The shared enabled D register the arbiter drives.
  always @(posedge clk) begin
    if (rst) sh_q <= '0;
    else if (reg_en) sh_q <= reg_d;
  end

  task automatic model_edge();
    bit was_pend = m_pend;
    if (rst) begin
      m_pend = 0; e_gnt = '0; e_reg_en = 0; e_reg_d = '0; e_last = 2'(NREQ - 1); e_sh = '0;
    end else begin
      if (e_reg_en) e_sh = e_reg_d;
      e_reg_en = 0;
      e_gnt    = '0;
      if (m_pend && m_edge == m_start + 1) begin
        e_reg_en = 1; e_reg_d = m_data;
      end
      if (m_pend && m_edge == m_start + 2) begin
        e_gnt = NREQ'(1) << m_win; e_last = 2'(m_win); m_pend = 0;
      end
      if (!was_pend && req != '0) begin
        bit found = 0;
        for (int j = 1; j <= NREQ; j++) begin
          int idx = (int'(e_last) + j) % NREQ;
          if (!found && req[idx]) begin
            found = 1; m_win = idx;
          end
        end
        m_pend = 1; m_start = m_edge; m_data = wdata[m_win*WIDTH +: WIDTH];
      end
    end
    m_edge++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req = '1; wdata = $urandom;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    checks++; if (reg_en !== 1'b0) begin failures++; $display("FAIL reset_reg_en got=%b want=0", reg_en); end
    checks++; if (reg_d !== 8'h00) begin failures++; $display("FAIL reset_reg_d got=%h want=00", reg_d); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (last_owner !== 2'd3) begin failures++; $display("FAIL reset_last got=%0d want=3", last_owner); end
    rst = 0; req = '0;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0010; wdata = $urandom; wdata[15:8] = 8'hA5;
    tick();
    req = '0; wdata = $urandom;
    tick();
    checks++; if (reg_en !== 1'b1) begin failures++; $display("FAIL single_reg_en got=%b want=1", reg_en); end
    checks++; if (reg_d !== 8'hA5) begin failures++; $display("FAIL single_reg_d got=%h want=a5", reg_d); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", busy); end
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL single_gnt got=%b want=0010", gnt); end
    checks++; if (reg_en !== 1'b0) begin failures++; $display("FAIL single_reg_en_off got=%b want=0", reg_en); end
    checks++; if (last_owner !== 2'd1) begin failures++; $display("FAIL single_last got=%0d want=1", last_owner); end
    checks++; if (sh_q !== 8'hA5) begin failures++; $display("FAIL single_shared_q got=%h want=a5", sh_q); end
    tick();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_order [5];
    logic [NREQ-1:0] got_order [5];
    int              got_edge  [5];
    int              n = 0;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    rst = 1; req = '0;
    tick();
    rst = 0; req = '1;
    for (int c = 0; c < 20; c++) begin
      wdata = $urandom;
      tick();
      if (gnt != '0 && n < 5) begin
        got_order[n] = gnt; got_edge[n] = c; n++;
      end
      req = ~gnt;
    end
    req = '0;
    tick(); tick(); tick();
    checks++; if (n != 5) begin failures++; $display("FAIL fair_count got=%0d want=5", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_order[k] !== exp_order[k]) begin
        failures++; $display("FAIL fair_order[%0d] got=%b want=%b", k, got_order[k], exp_order[k]);
      end
      if (k > 0) begin
        checks++;
        if (got_edge[k] - got_edge[k-1] != 3) begin
          failures++; $display("FAIL fair_spacing[%0d] got=%0d want=3", k, got_edge[k] - got_edge[k-1]);
        end
      end
    end
  endtask

  task automatic test_withdraw();
    req = 4'b0100; wdata = $urandom; wdata[23:16] = 8'h3C;
    tick();
    req = '0; wdata = '1;
    tick();
    checks++; if (reg_en !== 1'b1) begin failures++; $display("FAIL withdraw_reg_en got=%b want=1", reg_en); end
    checks++; if (reg_d !== 8'h3C) begin failures++; $display("FAIL withdraw_reg_d got=%h want=3c", reg_d); end
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL withdraw_gnt got=%b want=0100", gnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0001; wdata = $urandom; wdata[7:0] = 8'h5A;
    tick();
    req = '0;
    tick();
    checks++; if (reg_en !== 1'b1) begin failures++; $display("FAIL midrst_pre_en got=%b want=1", reg_en); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (reg_en !== 1'b0) begin failures++; $display("FAIL midrst_reg_en got=%b want=0", reg_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL midrst_gnt got=%b want=0000", gnt); end
    checks++; if (last_owner !== 2'd3) begin failures++; $display("FAIL midrst_last got=%0d want=3", last_owner); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000) begin failures++; $display("FAIL midrst_late_gnt c=%0d got=%b want=0000", c, gnt); end
    end
  endtask

  task automatic test_wrap();
    rst = 1; req = '0;
    tick();
    rst = 0; req = 4'b1001; wdata = $urandom;
    tick(); tick(); tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_first_gnt got=%b want=0001", gnt); end
    checks++; if (last_owner !== 2'd0) begin failures++; $display("FAIL wrap_first_last got=%0d want=0", last_owner); end
    tick(); tick(); tick();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL wrap_second_gnt got=%b want=1000", gnt); end
    checks++; if (last_owner !== 2'd3) begin failures++; $display("FAIL wrap_second_last got=%0d want=3", last_owner); end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      wdata = $urandom;
      rst   = ($urandom_range(0, 49) == 0);
      tick();
      checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL rand_gnt c=%0d got=%b want=%b", c, gnt, e_gnt); end
      checks++; if (reg_en !== e_reg_en) begin failures++; $display("FAIL rand_reg_en c=%0d got=%b want=%b", c, reg_en, e_reg_en); end
      checks++; if (reg_d !== e_reg_d) begin failures++; $display("FAIL rand_reg_d c=%0d got=%h want=%h", c, reg_d, e_reg_d); end
      checks++; if (busy !== (e_reg_en | (|e_gnt))) begin failures++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, busy, e_reg_en | (|e_gnt)); end
      checks++; if (last_owner !== e_last) begin failures++; $display("FAIL rand_last c=%0d got=%0d want=%0d", c, last_owner, e_last); end
      checks++; if (sh_q !== e_sh) begin failures++; $display("FAIL rand_shared_q c=%0d got=%h want=%h", c, sh_q, e_sh); end
    end
    rst = 0; req = '0;
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1; req = '0; wdata = '0;
    m_edge = 0; m_pend = 0; m_start = 0; m_win = 0; m_data = '0;
    e_gnt = '0; e_reg_en = 0; e_reg_d = '0; e_last = 2'(NREQ - 1); e_sh = '0;
    test_reset();
    test_single();
    test_fairness();
    test_withdraw();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
